mrsc_encoder_stream: RTL and testbench

- Streaming encoder for the 16-bit MRSC code; the decoder side consumes its 32-bit codewords.
- Accepts 16-bit data words over a valid/ready handshake and computes the 16 check bits in one registered stage.
- Buffers codewords in a small output FIFO that drains over a second valid/ready handshake.
- Sits between the data producer and the protected storage or link; also keeps a count of codewords emitted.

---
 rtl/mrsc_pkg.sv | 43 ++++
 rtl/mrsc_encoder_stream_if.sv | 21 ++
 rtl/mrsc_code_fifo.sv | 71 +++++++
 rtl/mrsc_encoder_stream.sv | 76 +++++++
 tb/tb_mrsc_encoder_stream.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mrsc_pkg.sv
// rtl/mrsc_pkg.sv - MRSC 16-bit code constants and the shared encode function
package mrsc_pkg;

    localparam int ROWS   = 4;
    localparam int ROW_W  = 8;
    localparam int DATA_W = 16;
    localparam int CODE_W = 32;

    // Check-bit positions inside a row, MSB-first numbering
    localparam int CHK_X        = 4;
    localparam int CHK_Y        = 5;
    localparam int CHK_ROW_EVEN = 6;
    localparam int CHK_ROW_ODD  = 7;

    function automatic logic [CODE_W-1:0] mrsc_encode(input logic [DATA_W-1:0] data);
        logic [0:DATA_W-1] d;
        logic [0:CODE_W-1] c;
        logic [0:3]        col;
        d = data;
        c = '0;
        for (int b = 0; b < ROWS; b++) begin
            for (int k = 0; k < 4; k++) begin
                c[b*ROW_W + k] = d[4*b + k];
            end
            c[b*ROW_W + CHK_ROW_EVEN] = d[4*b]     ^ d[4*b + 2];
            c[b*ROW_W + CHK_ROW_ODD]  = d[4*b + 1] ^ d[4*b + 3];
        end
        for (int k = 0; k < 4; k++) begin
            col[k] = d[k] ^ d[4 + k] ^ d[8 + k] ^ d[12 + k];
        end
        c[2*ROW_W + CHK_X] = col[0];
        c[3*ROW_W + CHK_X] = col[1];
        c[2*ROW_W + CHK_Y] = col[2];
        c[3*ROW_W + CHK_Y] = col[3];
        // Diagonals alternate between the even and odd bit of each pair row by row
        c[0*ROW_W + CHK_X] = d[0] ^ d[5] ^ d[8]  ^ d[13];
        c[1*ROW_W + CHK_X] = d[1] ^ d[4] ^ d[9]  ^ d[12];
        c[0*ROW_W + CHK_Y] = d[2] ^ d[7] ^ d[10] ^ d[15];
        c[1*ROW_W + CHK_Y] = d[3] ^ d[6] ^ d[11] ^ d[14];
        return c;
    endfunction

endpackage

// File: rtl/mrsc_encoder_stream_if.sv
// rtl/mrsc_encoder_stream_if.sv - input word and output codeword handshakes of the encoder
interface mrsc_encoder_stream_if;
    import mrsc_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_code
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_code
    );
endinterface

// File: rtl/mrsc_code_fifo.sv
// rtl/mrsc_code_fifo.sv - circular codeword buffer with registered ready/valid flags
module mrsc_code_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_ready,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW:0]   L_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_ready;
    logic          r_valid;

    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_count_nxt;

    // A full buffer refuses pushes even while popping: no push-through
    assign w_push = i_push & r_ready;
    assign w_pop  = i_pop  & r_valid;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != L_FULL);
            r_valid <= (w_count_nxt != '0);
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_data  = r_mem[r_rptr];

endmodule

// File: rtl/mrsc_encoder_stream.sv
// rtl/mrsc_encoder_stream.sv - streaming MRSC encoder with output FIFO and emit counter
// Optional error injection port set enabled by MRSC_ERR_INJECT_EN.
module mrsc_encoder_stream
    import mrsc_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    mrsc_encoder_stream_if.slave bus,
`ifdef MRSC_ERR_INJECT_EN
    input  logic [CODE_W-1:0]  err_mask,
    input  logic               err_inject,
    output logic [CNT_W-1:0]   inj_count,
`endif
    output logic [CNT_W-1:0]   enc_count,
    output logic               busy
);

    logic [CODE_W-1:0] w_code;
    logic [CODE_W-1:0] w_wr_code;
    logic [CODE_W-1:0] w_head;
    logic              w_in_ready;
    logic              w_out_valid;
    logic [CNT_W-1:0]  r_enc_count;

    assign w_code = mrsc_encode(bus.in_data);

`ifdef MRSC_ERR_INJECT_EN
    logic [CNT_W-1:0] r_inj_count;

    assign w_wr_code = err_inject ? (w_code ^ err_mask) : w_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inj_count <= '0;
        end else if (bus.in_valid && w_in_ready && err_inject) begin
            r_inj_count <= r_inj_count + 1'b1;
        end
    end

    assign inj_count = r_inj_count;
`else
    assign w_wr_code = w_code;
`endif

    mrsc_code_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CODE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.in_valid),
        .i_data  (w_wr_code),
        .o_ready (w_in_ready),
        .i_pop   (bus.out_ready),
        .o_valid (w_out_valid),
        .o_data  (w_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enc_count <= '0;
        end else if (w_out_valid && bus.out_ready) begin
            r_enc_count <= r_enc_count + 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_code  = w_head;
    assign enc_count     = r_enc_count;
    assign busy          = w_out_valid;

endmodule

// File: tb/tb_mrsc_encoder_stream.sv
// tb/tb_mrsc_encoder_stream.sv - scoreboard bench for the MRSC streaming encoder
module tb_mrsc_encoder_stream;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic [15:0] data;
        logic [31:0] code;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [CNT_W-1:0] enc_count;
    logic             busy;
`ifdef MRSC_ERR_INJECT_EN
    logic [31:0]      err_mask = '0;
    logic             err_inject = 1'b0;
    logic [CNT_W-1:0] inj_count;
`endif

    mrsc_encoder_stream_if bus_if ();

    mrsc_encoder_stream #(
        .FIFO_DEPTH (2),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
`ifdef MRSC_ERR_INJECT_EN
        .err_mask   (err_mask),
        .err_inject (err_inject),
        .inj_count  (inj_count),
`endif
        .enc_count  (enc_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_errors = 0;
    exp_t             exp_q[$];
    logic [CNT_W-1:0] pop_model = '0;
    bit               rnd_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference built as a 4x8 grid: row pairs, column parity, alternating diagonals
    function automatic logic [31:0] ref_encode(input logic [15:0] w);
        bit          r[4][8];
        bit          p;
        logic [31:0] c;
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 8; k++) r[b][k] = 1'b0;
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 4; k++) r[b][k] = w[15 - (4*b + k)];
        for (int b = 0; b < 4; b++) begin
            r[b][6] = r[b][0] ^ r[b][2];
            r[b][7] = r[b][1] ^ r[b][3];
        end
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int b = 0; b < 4; b++) p ^= r[b][k];
            r[2 + k % 2][4 + k / 2] = p;
        end
        for (int j = 0; j < 4; j++) begin
            p = 1'b0;
            for (int b = 0; b < 4; b++) p ^= r[b][j ^ (b % 2)];
            r[j % 2][4 + j / 2] = p;
        end
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 8; k++) c[31 - (8*b + k)] = r[b][k];
        return c;
    endfunction

    function automatic logic [15:0] decode(input logic [31:0] c);
        logic [15:0] d;
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 4; k++) d[15 - (4*b + k)] = c[31 - (8*b + k)];
        return d;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("enc_count", 64'(enc_count), 64'(pop_model));
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_out: got %h expected no codeword", bus_if.out_code);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_code", 64'(bus_if.out_code), 64'(e.code));
                    chk("decoded", 64'(decode(bus_if.out_code)), 64'(e.data));
                end
                pop_model = pop_model + 1'b1;
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic [31:0] exp_code, input logic [15:0] exp_dec);
        bit   ok;
        exp_t e;
        ok = 0;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus_if.in_ready) begin
                e.data = exp_dec;
                e.code = exp_code;
                exp_q.push_back(e);
                ok = 1;
            end
            @(posedge clk);
            #1;
        end
        bus_if.in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: got in_ready=0 for 200 cycles expected acceptance of %h", d);
        end
    endtask

    task automatic send_enc(input logic [15:0] d);
        send(d, ref_encode(d), d);
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while ((exp_q.size() != 0 || bus_if.out_valid) && i < 200) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        exp_q.delete();
        pop_model = '0;
        #1;
        chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("rst_enc_count", 64'(enc_count), 64'd0);
        chk("rst_out_code", 64'(bus_if.out_code), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] wa, wb, wc;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.out_ready = 1'b0;
        apply_reset();

        bus_if.out_ready = 1'b1;
        send(16'hFFFF, 32'hF0F0F0F0, 16'hFFFF);
        chk("latency_valid", 64'(bus_if.out_valid), 64'd1);
        chk("busy_high", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        chk("enc_count_first", 64'(enc_count), 64'd1);
        send(16'h8000, 32'h8A000800, 16'h8000);
        send(16'h1000, 32'h11040004, 16'h1000);
        send(16'h0000, 32'h00000000, 16'h0000);
        wait_drain();

        wa = 16'($urandom_range(0, 65535));
        wb = 16'($urandom_range(0, 65535));
        wc = 16'($urandom_range(0, 65535));
        bus_if.out_ready = 1'b0;
        send_enc(wa);
        send_enc(wb);
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = wc;
        repeat (3) begin
            @(negedge clk);
            chk("full_in_ready", 64'(bus_if.in_ready), 64'd0);
        end
        chk("full_head", 64'(bus_if.out_code), 64'(ref_encode(wa)));
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b1;
        send_enc(wc);
        wait_drain();

        apply_reset();
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) send_enc(16'($urandom_range(0, 65535)));
        wait_drain();
        chk("enc_wrap", 64'(enc_count), 64'd1);

        bus_if.out_ready = 1'b0;
        send_enc(16'h1234);
        send_enc(16'hABCD);
        chk("mid_busy", 64'(busy), 64'd1);
        apply_reset();
        bus_if.out_ready = 1'b1;

`ifdef MRSC_ERR_INJECT_EN
        chk("inj_count_rst", 64'(inj_count), 64'd0);
        err_mask   = 32'h80000000;
        err_inject = 1'b1;
        send(16'hFFFF, 32'h70F0F0F0, 16'h7FFF);
        err_inject = 1'b0;
        chk("inj_count", 64'(inj_count), 64'd1);
        wait_drain();
`endif

        fork
            begin
                for (int i = 0; i < 10000; i++) send_enc(16'($urandom_range(0, 65535)));
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus_if.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus_if.out_ready = 1'b1;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
